// File: rtl/e203_sleep_seq_pkg.sv
// Shared constants for the WFI sleep sequencer: state encoding and default delays.
package e203_sleep_seq_pkg;

    localparam logic [1:0] SLP_RUN   = 2'd0;
    localparam logic [1:0] SLP_DRAIN = 2'd1;
    localparam logic [1:0] SLP_SLEEP = 2'd2;
    localparam logic [1:0] SLP_WAKE  = 2'd3;

    localparam int DRAIN_DLY_DEF = 2;
    localparam int WAKE_DLY_DEF  = 2;

    // Idle and settle counters only ever need to reach 15.
    localparam int DLY_CNT_W = 4;

endpackage

// File: rtl/e203_sat_cnt.sv
// Saturating up-counter with synchronous clear and enable; clear wins over enable.
module e203_sat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/e203_sleep_seq.sv
// WFI sleep sequencer: halts the IFU, waits for the pipeline to drain, raises core_wfi,
// and on a wake source holds the halt for a settle window before resuming fetch.
module e203_sleep_seq
    import e203_sleep_seq_pkg::*;
#(
    parameter int DRAIN_DLY = DRAIN_DLY_DEF,
    parameter int WAKE_DLY  = WAKE_DLY_DEF,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wfi_req,
    output logic             wfi_ack,
    input  logic             dbg_mode,
    output logic             halt_ifu_req,
    input  logic             ifu_halt_ack,
    input  logic             exu_idle,
    input  logic             lsu_idle,
    input  logic             biu_idle,
    input  logic [2:0]       irq_pend,
    input  logic             dbg_irq,
    output logic             core_wfi,
    output logic             wake_evt,
    output logic [CNT_W-1:0] sleep_cycles
);

    localparam logic [DLY_CNT_W-1:0] DRAIN_LAST = DLY_CNT_W'(DRAIN_DLY - 1);
    localparam logic [DLY_CNT_W-1:0] WAKE_LAST  = DLY_CNT_W'(WAKE_DLY - 1);

    logic [1:0] state_q, state_d;
    logic       wfi_ack_q, wfi_ack_d;
    logic       halt_q, halt_d;
    logic       core_wfi_q, core_wfi_d;
    logic       wake_evt_q, wake_evt_d;

    logic                 wake_src;
    logic                 all_idle;
    logic [DLY_CNT_W-1:0] idle_cnt;
    logic [DLY_CNT_W-1:0] settle_cnt;

    assign wake_src = (|irq_pend) | dbg_irq;
    assign all_idle = ifu_halt_ack & exu_idle & lsu_idle & biu_idle;

    // Wake sources take priority over drain completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLP_RUN: begin
                if (wfi_req && !dbg_mode && !wake_src) begin
                    state_d = SLP_DRAIN;
                end
            end
            SLP_DRAIN: begin
                if (wake_src) begin
                    state_d = SLP_WAKE;
                end else if (all_idle && (idle_cnt == DRAIN_LAST)) begin
                    state_d = SLP_SLEEP;
                end
            end
            SLP_SLEEP: begin
                if (wake_src) begin
                    state_d = SLP_WAKE;
                end
            end
            SLP_WAKE: begin
                if (settle_cnt == WAKE_LAST) begin
                    state_d = SLP_RUN;
                end
            end
            default: state_d = SLP_RUN;
        endcase
    end

    always_comb begin
        wfi_ack_d  = (state_q == SLP_RUN) && wfi_req;
        halt_d     = (state_d != SLP_RUN);
        core_wfi_d = (state_d == SLP_SLEEP);
        wake_evt_d = (state_q == SLP_SLEEP) && wake_src;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SLP_RUN;
            wfi_ack_q  <= 1'b0;
            halt_q     <= 1'b0;
            core_wfi_q <= 1'b0;
            wake_evt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wfi_ack_q  <= wfi_ack_d;
            halt_q     <= halt_d;
            core_wfi_q <= core_wfi_d;
            wake_evt_q <= wake_evt_d;
        end
    end

    e203_sat_cnt #(.W(DLY_CNT_W)) u_idle_cnt (
        .clk (clk),
        .rst (rst),
        .clr ((state_q != SLP_DRAIN) || !all_idle),
        .en  (1'b1),
        .cnt (idle_cnt)
    );

    e203_sat_cnt #(.W(DLY_CNT_W)) u_settle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q != SLP_WAKE),
        .en  (1'b1),
        .cnt (settle_cnt)
    );

    // Sleep duration is cleared only on SLEEP entry so the last value stays visible.
    e203_sat_cnt #(.W(CNT_W)) u_sleep_cnt (
        .clk (clk),
        .rst (rst),
        .clr ((state_q == SLP_DRAIN) && (state_d == SLP_SLEEP)),
        .en  (state_q == SLP_SLEEP),
        .cnt (sleep_cycles)
    );

    assign wfi_ack      = wfi_ack_q;
    assign halt_ifu_req = halt_q;
    assign core_wfi     = core_wfi_q;
    assign wake_evt     = wake_evt_q;

endmodule

// File: tb/tb_e203_sleep_seq.sv
// Randomized and directed bench for e203_sleep_seq against a cycle-level reference model;
// a second instance with a 4-bit duration counter exercises saturation.
module tb_e203_sleep_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wfi_req = 1'b0;
    logic        dbg_mode = 1'b0;
    logic        ifu_halt_ack = 1'b0;
    logic        exu_idle = 1'b0;
    logic        lsu_idle = 1'b0;
    logic        biu_idle = 1'b0;
    logic [2:0]  irq_pend = 3'b000;
    logic        dbg_irq = 1'b0;

    logic        wfi_ack_w, halt_w, core_wfi_w, wake_evt_w;
    logic [31:0] sleep_w;
    logic        wfi_ack_n, halt_n, core_wfi_n, wake_evt_n;
    logic [3:0]  sleep_n;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    e203_sleep_seq #(.DRAIN_DLY(2), .WAKE_DLY(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .wfi_req(wfi_req), .wfi_ack(wfi_ack_w), .dbg_mode(dbg_mode),
        .halt_ifu_req(halt_w), .ifu_halt_ack(ifu_halt_ack), .exu_idle(exu_idle),
        .lsu_idle(lsu_idle), .biu_idle(biu_idle), .irq_pend(irq_pend), .dbg_irq(dbg_irq),
        .core_wfi(core_wfi_w), .wake_evt(wake_evt_w), .sleep_cycles(sleep_w)
    );

    e203_sleep_seq #(.DRAIN_DLY(2), .WAKE_DLY(2), .CNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .wfi_req(wfi_req), .wfi_ack(wfi_ack_n), .dbg_mode(dbg_mode),
        .halt_ifu_req(halt_n), .ifu_halt_ack(ifu_halt_ack), .exu_idle(exu_idle),
        .lsu_idle(lsu_idle), .biu_idle(biu_idle), .irq_pend(irq_pend), .dbg_irq(dbg_irq),
        .core_wfi(core_wfi_n), .wake_evt(wake_evt_n), .sleep_cycles(sleep_n)
    );

    // Reference model: phases with a drain run-length, a settle countdown and an unbounded sleep length.
    typedef enum int {M_RUN, M_DRAIN, M_SLEEP, M_WAKE} mphase_t;
    localparam int M_DRAIN_DLY = 2;
    localparam int M_WAKE_DLY  = 2;

    mphase_t m_phase = M_RUN;
    int      m_idle_run = 0;
    int      m_settle_left = 0;
    longint  m_sleep_len = 0;
    bit      m_ack = 1'b0;
    bit      m_wevt = 1'b0;

    task automatic modelStep();
        bit wake;
        bit idle;
        wake   = (irq_pend != 3'b000) || dbg_irq;
        idle   = ifu_halt_ack && exu_idle && lsu_idle && biu_idle;
        m_ack  = 1'b0;
        m_wevt = 1'b0;
        if (rst) begin
            m_phase = M_RUN;
            m_idle_run = 0;
            m_settle_left = 0;
            m_sleep_len = 0;
        end else begin
            case (m_phase)
                M_RUN: begin
                    if (wfi_req) begin
                        m_ack = 1'b1;
                        if (!(dbg_mode || wake)) begin
                            m_phase = M_DRAIN;
                            m_idle_run = 0;
                        end
                    end
                end
                M_DRAIN: begin
                    if (wake) begin
                        m_phase = M_WAKE;
                        m_settle_left = M_WAKE_DLY;
                    end else if (idle) begin
                        m_idle_run++;
                        if (m_idle_run == M_DRAIN_DLY) begin
                            m_phase = M_SLEEP;
                            m_sleep_len = 0;
                        end
                    end else begin
                        m_idle_run = 0;
                    end
                end
                M_SLEEP: begin
                    m_sleep_len++;
                    if (wake) begin
                        m_phase = M_WAKE;
                        m_settle_left = M_WAKE_DLY;
                        m_wevt = 1'b1;
                    end
                end
                default: begin
                    m_settle_left--;
                    if (m_settle_left == 0) m_phase = M_RUN;
                end
            endcase
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compareAll();
        longint lim_w;
        lim_w = (m_sleep_len > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sleep_len;
        checkOutput("wfi_ack", {63'd0, wfi_ack_w}, {63'd0, m_ack});
        checkOutput("halt_ifu_req", {63'd0, halt_w}, {63'd0, m_phase != M_RUN});
        checkOutput("core_wfi", {63'd0, core_wfi_w}, {63'd0, m_phase == M_SLEEP});
        checkOutput("wake_evt", {63'd0, wake_evt_w}, {63'd0, m_wevt});
        checkOutput("sleep_cycles", {32'd0, sleep_w}, lim_w);
        checkOutput("n_wfi_ack", {63'd0, wfi_ack_n}, {63'd0, m_ack});
        checkOutput("n_halt_ifu_req", {63'd0, halt_n}, {63'd0, m_phase != M_RUN});
        checkOutput("n_core_wfi", {63'd0, core_wfi_n}, {63'd0, m_phase == M_SLEEP});
        checkOutput("n_wake_evt", {63'd0, wake_evt_n}, {63'd0, m_wevt});
        checkOutput("n_sleep_cycles", {60'd0, sleep_n}, (m_sleep_len > 15) ? 64'd15 : m_sleep_len);
    endtask

    // Drives one cycle of inputs just after a rising edge, then checks the following cycle.
    task automatic applyStimulus(input logic r, input logic wr, input logic dm, input logic ha,
                                 input logic ei, input logic li, input logic bi,
                                 input logic [2:0] irq, input logic di);
        rst = r; wfi_req = wr; dbg_mode = dm; ifu_halt_ack = ha;
        exu_idle = ei; lsu_idle = li; biu_idle = bi; irq_pend = irq; dbg_irq = di;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, 1, 1, 1, 3'b000, 0);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        checkOutput("reset_halt", {63'd0, halt_w}, 64'd0);
        checkOutput("reset_sleep", {32'd0, sleep_w}, 64'd0);

        // Basic sleep: request, two idle cycles, seven more asleep, then a timer-free ext irq.
        idleCycles(7);
        applyStimulus(0, 1, 0, 1, 1, 1, 1, 3'b000, 0);
        checkOutput("basic_ack", {63'd0, wfi_ack_w}, 64'd1);
        idleCycles(1);
        checkOutput("basic_wfi_early", {63'd0, core_wfi_w}, 64'd0);
        idleCycles(1);
        checkOutput("basic_wfi_rise", {63'd0, core_wfi_w}, 64'd1);
        idleCycles(7);
        applyStimulus(0, 0, 0, 1, 1, 1, 1, 3'b100, 0);
        checkOutput("basic_wake_evt", {63'd0, wake_evt_w}, 64'd1);
        checkOutput("basic_sleep_len", {32'd0, sleep_w}, 64'd8);
        idleCycles(1);
        checkOutput("basic_halt_hold", {63'd0, halt_w}, 64'd1);
        idleCycles(1);
        checkOutput("basic_halt_drop", {63'd0, halt_w}, 64'd0);

        // NOP cases.
        applyStimulus(0, 1, 0, 1, 1, 1, 1, 3'b010, 0);
        checkOutput("nop_irq_ack", {63'd0, wfi_ack_w}, 64'd1);
        checkOutput("nop_irq_halt", {63'd0, halt_w}, 64'd0);
        applyStimulus(0, 1, 1, 1, 1, 1, 1, 3'b000, 0);
        checkOutput("nop_dbg_halt", {63'd0, halt_w}, 64'd0);
        idleCycles(2);

        // Drain stall: lsu_idle 1,0,1,1.
        applyStimulus(0, 1, 0, 1, 1, 1, 1, 3'b000, 0);
        applyStimulus(0, 0, 0, 1, 1, 1, 1, 3'b000, 0);
        applyStimulus(0, 0, 0, 1, 1, 0, 1, 3'b000, 0);
        applyStimulus(0, 0, 0, 1, 1, 1, 1, 3'b000, 0);
        checkOutput("stall_wfi_low", {63'd0, core_wfi_w}, 64'd0);
        applyStimulus(0, 0, 0, 1, 1, 1, 1, 3'b000, 0);
        checkOutput("stall_wfi_high", {63'd0, core_wfi_w}, 64'd1);
        // Idle dropping while asleep must not wake.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        checkOutput("idle_drop_sleep", {63'd0, core_wfi_w}, 64'd1);
        applyStimulus(0, 0, 0, 1, 1, 1, 1, 3'b001, 0);
        idleCycles(3);

        // Drain abort via debug irq while the IFU has not acknowledged.
        applyStimulus(0, 1, 0, 0, 1, 1, 1, 3'b000, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 3'b000, 1);
        checkOutput("abort_no_evt", {63'd0, wake_evt_w}, 64'd0);
        checkOutput("abort_halt", {63'd0, halt_w}, 64'd1);
        idleCycles(2);
        checkOutput("abort_run", {63'd0, halt_w}, 64'd0);

        // Saturation of the narrow counter over a 20-cycle sleep.
        applyStimulus(0, 1, 0, 1, 1, 1, 1, 3'b000, 0);
        idleCycles(21);
        applyStimulus(0, 0, 0, 1, 1, 1, 1, 3'b000, 1);
        idleCycles(4);
        checkOutput("sat_narrow", {60'd0, sleep_n}, 64'd15);
        checkOutput("sat_wide", {32'd0, sleep_w}, 64'd20);

        // Reset while asleep, then a fresh sequence.
        applyStimulus(0, 1, 0, 1, 1, 1, 1, 3'b000, 0);
        idleCycles(5);
        applyStimulus(1, 0, 0, 1, 1, 1, 1, 3'b000, 0);
        checkOutput("rst_sleep_wfi", {63'd0, core_wfi_w}, 64'd0);
        checkOutput("rst_sleep_cnt", {32'd0, sleep_w}, 64'd0);
        applyStimulus(0, 1, 0, 1, 1, 1, 1, 3'b000, 0);
        idleCycles(2);
        checkOutput("rst_resleep", {63'd0, core_wfi_w}, 64'd1);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 15) != 0), ($urandom_range(0, 15) != 0),
                          ($urandom_range(0, 15) != 0),
                          ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                          ($urandom_range(0, 31) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
